pe_fp_acc: RTL and testbench

- FP32 systolic processing element with an operand FIFO that decouples the 1-cycle systolic flow from the multi-cycle, handshaked FPU multiplier and adder.
- Accumulates exactly ACC_LEN products, then presents the dot-product result on a valid/ready port.
- Forwards weights and data to its neighbours unchanged, with 1-cycle latency.
- Sits in the systolic array in place of the single-accumulator PE and is the building block for output-stationary tiles.

---
 rtl/pe_fp_acc.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_pe_fp_acc.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_fp_acc.sv
// FP32 systolic PE: forwards operands, queues pairs, and accumulates ACC_LEN products through
// handshaked FP units. Optional `define PE_ZERO_SKIP_EN bypasses pairs holding a +/-0.0 operand.

module pe_fp_unit #(
    parameter bit IS_ADD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    logic        have_a_q, have_b_q, z_vld_q;
    logic [31:0] a_q, b_q, z_q, z_calc;

    function automatic int exp_of(input logic [31:0] x);
        return (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
    endfunction

    // Round-to-nearest-even; products that underflow the normal range flush to signed zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        sz, g, s;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [23:0] ma, mb, m;
        logic [47:0] p;
        logic [24:0] mr;
        int          e, lead;
        sz     = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hff) && (a[22:0] != 23'h0);
        b_nan  = (b[30:23] == 8'hff) && (b[22:0] != 23'h0);
        a_inf  = (a[30:23] == 8'hff) && (a[22:0] == 23'h0);
        b_inf  = (b[30:23] == 8'hff) && (b[22:0] == 23'h0);
        a_zero = (a[30:0] == 31'h0);
        b_zero = (b[30:0] == 31'h0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7fc00000;
        if (a_inf || b_inf) return {sz, 8'hff, 23'h0};
        if (a_zero || b_zero) return {sz, 31'h0};
        ma   = {a[30:23] != 8'd0, a[22:0]};
        mb   = {b[30:23] != 8'd0, b[22:0]};
        p    = {24'h0, ma} * {24'h0, mb};
        lead = 0;
        for (int i = 0; i < 48; i++) begin
            if (p[i]) lead = i;
        end
        e  = exp_of(a) + exp_of(b) - 127 + lead - 46;
        p  = p << (47 - lead);
        m  = p[47:24];
        g  = p[23];
        s  = |p[22:0];
        mr = {1'b0, m} + {24'h0, g & (s | m[0])};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 1;
        end
        if (e >= 255) return {sz, 8'hff, 23'h0};
        if (e <= 0) return {sz, 31'h0};
        return {sz, e[7:0], mr[22:0]};
    endfunction

    // Round-to-nearest-even with guard/round/sticky; subnormal inputs and results supported.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic        a_nan, b_nan, a_inf, b_inf, sa, sb, g, s;
        logic [31:0] x, y;
        logic [23:0] m;
        logic [27:0] wa, wb, r;
        logic [24:0] mr;
        int          xa, xb, d, e;
        a_nan = (a[30:23] == 8'hff) && (a[22:0] != 23'h0);
        b_nan = (b[30:23] == 8'hff) && (b[22:0] != 23'h0);
        a_inf = (a[30:23] == 8'hff) && (a[22:0] == 23'h0);
        b_inf = (b[30:23] == 8'hff) && (b[22:0] == 23'h0);
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return 32'h7fc00000;
        if (a_inf) return a;
        if (b_inf) return b;
        if ((a[30:0] == 31'h0) && (b[30:0] == 31'h0)) return {a[31] & b[31], 31'h0};
        if (a[30:0] < b[30:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end
        sa = x[31];
        sb = y[31];
        xa = exp_of(x);
        xb = exp_of(y);
        wa = {1'b0, x[30:23] != 8'd0, x[22:0], 3'b000};
        wb = {1'b0, y[30:23] != 8'd0, y[22:0], 3'b000};
        d  = xa - xb;
        for (int i = 0; i < 28; i++) begin
            if (i < d) wb = (wb >> 1) | {27'h0, wb[0]};
        end
        r = (sa == sb) ? wa + wb : wa - wb;
        if (r == 28'h0) return 32'h0;
        e = xa;
        if (r[27]) begin
            r = (r >> 1) | {27'h0, r[0]};
            e = e + 1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!r[26] && (e > 1)) begin
                    r = r << 1;
                    e = e - 1;
                end
            end
        end
        m  = r[26:3];
        g  = r[2];
        s  = |r[1:0];
        mr = {1'b0, m} + {24'h0, g & (s | m[0])};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 1;
        end
        if (e >= 255) return {sa, 8'hff, 23'h0};
        return {sa, (mr[23] ? e[7:0] : 8'h00), mr[22:0]};
    endfunction

    assign input_a_ack  = !have_a_q && !z_vld_q;
    assign input_b_ack  = !have_b_q && !z_vld_q;
    assign output_z     = z_q;
    assign output_z_stb = z_vld_q;

    always_comb begin
        z_calc = IS_ADD ? fp_add(a_q, b_q) : fp_mul(a_q, b_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_a_q <= 1'b0;
            have_b_q <= 1'b0;
            z_vld_q  <= 1'b0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            z_q      <= 32'h0;
        end else begin
            if (input_a_stb && input_a_ack) begin
                a_q      <= input_a;
                have_a_q <= 1'b1;
            end
            if (input_b_stb && input_b_ack) begin
                b_q      <= input_b;
                have_b_q <= 1'b1;
            end
            if (have_a_q && have_b_q && !z_vld_q) begin
                z_q      <= z_calc;
                z_vld_q  <= 1'b1;
                have_a_q <= 1'b0;
                have_b_q <= 1'b0;
            end else if (z_vld_q && output_z_ack) begin
                z_vld_q <= 1'b0;
            end
        end
    end

endmodule

module pe_fp_acc #(
    parameter int unsigned FPW        = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ACC_LEN    = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [FPW-1:0] in_w,
    input  logic [FPW-1:0] in_d,
    input  logic           in_v,
    output logic [FPW-1:0] out_w,
    output logic [FPW-1:0] out_d,
    output logic           out_v,
    input  logic           acc_clr,
    output logic [31:0]    res_z,
    output logic           res_v,
    input  logic           res_rdy,
    output logic           busy,
    output logic           ovf
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(ACC_LEN + 1);
    localparam logic [CW-1:0] ACC_CNT = CW'(ACC_LEN);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StMulLd = 3'd1,
        StMulWt = 3'd2,
        StAddLd = 3'd3,
        StAddWt = 3'd4,
        StDone  = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [2*FPW-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic              fifo_empty, fifo_full, push, pop, fifo_clr, do_clr;
    logic [FPW-1:0]    head_w, head_d, op_w_q, op_d_q;
    logic [31:0]       acc_q, acc_d, prod_q, prod_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic              a_done_q, a_done_d, b_done_q, b_done_d, clr_pend_q, clr_pend_d, ovf_q;
    logic              mul_a_stb, mul_a_ack, mul_b_stb, mul_b_ack, mul_z_stb, mul_z_ack;
    logic              add_a_stb, add_a_ack, add_b_stb, add_b_ack, add_z_stb, add_z_ack;
    logic [31:0]       mul_z, add_z;

    pe_fp_unit #(.IS_ADD(1'b0)) u_mul (
        .clk          (clk),
        .rst          (~rstn),
        .input_a      (op_w_q),
        .input_a_stb  (mul_a_stb),
        .input_a_ack  (mul_a_ack),
        .input_b      (op_d_q),
        .input_b_stb  (mul_b_stb),
        .input_b_ack  (mul_b_ack),
        .output_z     (mul_z),
        .output_z_stb (mul_z_stb),
        .output_z_ack (mul_z_ack)
    );

    pe_fp_unit #(.IS_ADD(1'b1)) u_add (
        .clk          (clk),
        .rst          (~rstn),
        .input_a      (acc_q),
        .input_a_stb  (add_a_stb),
        .input_a_ack  (add_a_ack),
        .input_b      (prod_q),
        .input_b_stb  (add_b_stb),
        .input_b_ack  (add_b_ack),
        .output_z     (add_z),
        .output_z_stb (add_z_stb),
        .output_z_ack (add_z_ack)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_w <= '0;
            out_d <= '0;
            out_v <= 1'b0;
        end else begin
            out_w <= in_w;
            out_d <= in_d;
            out_v <= in_v;
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign {head_w, head_d} = mem_q[rd_ptr_q[AW-1:0]];
    assign push       = in_v && (!fifo_full || pop) && !fifo_clr;
    assign cnt_inc    = cnt_q + CW'(1);

    assign res_z = acc_q;
    assign res_v = (state_q == StDone);
    assign busy  = (state_q != StIdle) || !fifo_empty;
    assign ovf   = ovf_q;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        do_clr     = 1'b0;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        prod_d     = prod_q;
        a_done_d   = a_done_q;
        b_done_d   = b_done_q;
        clr_pend_d = clr_pend_q;
        mul_a_stb  = 1'b0;
        mul_b_stb  = 1'b0;
        mul_z_ack  = 1'b0;
        add_a_stb  = 1'b0;
        add_b_stb  = 1'b0;
        add_z_ack  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (acc_clr) begin
                    do_clr = 1'b1;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StMulLd;
`ifdef PE_ZERO_SKIP_EN
                    if ((head_w[30:0] == 31'h0) || (head_d[30:0] == 31'h0)) begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == ACC_CNT) ? StDone : StIdle;
                    end
`endif
                end
            end
            StMulLd: begin
                mul_a_stb = !a_done_q;
                mul_b_stb = !b_done_q;
                if (mul_a_stb && mul_a_ack) a_done_d = 1'b1;
                if (mul_b_stb && mul_b_ack) b_done_d = 1'b1;
                if (a_done_d && b_done_d) begin
                    a_done_d = 1'b0;
                    b_done_d = 1'b0;
                    state_d  = StMulWt;
                end
                if (acc_clr) clr_pend_d = 1'b1;
            end
            StMulWt: begin
                mul_z_ack = 1'b1;
                if (mul_z_stb) begin
                    prod_d  = mul_z;
                    state_d = StAddLd;
                end
                if (acc_clr) clr_pend_d = 1'b1;
            end
            StAddLd: begin
                add_a_stb = !a_done_q;
                add_b_stb = !b_done_q;
                if (add_a_stb && add_a_ack) a_done_d = 1'b1;
                if (add_b_stb && add_b_ack) b_done_d = 1'b1;
                if (a_done_d && b_done_d) begin
                    a_done_d = 1'b0;
                    b_done_d = 1'b0;
                    state_d  = StAddWt;
                end
                if (acc_clr) clr_pend_d = 1'b1;
            end
            StAddWt: begin
                add_z_ack = 1'b1;
                if (add_z_stb) begin
                    // A pending abort drops this sum and applies the clear in its place.
                    if (clr_pend_q || acc_clr) begin
                        do_clr = 1'b1;
                    end else begin
                        acc_d   = add_z;
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == ACC_CNT) ? StDone : StIdle;
                    end
                end else if (acc_clr) begin
                    clr_pend_d = 1'b1;
                end
            end
            StDone: begin
                if (acc_clr) begin
                    do_clr = 1'b1;
                end else if (res_rdy) begin
                    acc_d   = 32'h0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (do_clr) begin
            acc_d      = 32'h0;
            cnt_d      = '0;
            clr_pend_d = 1'b0;
            a_done_d   = 1'b0;
            b_done_d   = 1'b0;
            state_d    = StIdle;
        end
        fifo_clr = do_clr;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            acc_q      <= 32'h0;
            prod_q     <= 32'h0;
            cnt_q      <= '0;
            a_done_q   <= 1'b0;
            b_done_q   <= 1'b0;
            clr_pend_q <= 1'b0;
            op_w_q     <= '0;
            op_d_q     <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            cnt_q      <= cnt_d;
            a_done_q   <= a_done_d;
            b_done_q   <= b_done_d;
            clr_pend_q <= clr_pend_d;
            if (pop) begin
                op_w_q <= head_w;
                op_d_q <= head_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (fifo_clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {in_w, in_d};
                wr_ptr_q                <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (in_v && !push) ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pe_fp_acc.sv
// Scoreboard bench for pe_fp_acc (ACC_LEN=4, FIFO_DEPTH=4): stimulus queues expected results,
// a negedge monitor pops and compares on every accepted res_v.

module tb_pe_fp_acc;

    localparam int unsigned ACC_LEN    = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [31:0] F_0   = 32'h00000000;
    localparam logic [31:0] F_025 = 32'h3E800000;
    localparam logic [31:0] F_N05 = 32'hBF000000;
    localparam logic [31:0] F_1   = 32'h3F800000;
    localparam logic [31:0] F_15  = 32'h3FC00000;
    localparam logic [31:0] F_2   = 32'h40000000;
    localparam logic [31:0] F_3   = 32'h40400000;
    localparam logic [31:0] F_4   = 32'h40800000;
    localparam logic [31:0] F_5   = 32'h40A00000;
    localparam logic [31:0] F_16  = 32'h41800000;

    logic        clk, rstn, in_v, out_v, acc_clr, res_v, res_rdy, busy, ovf;
    logic [31:0] in_w, in_d, out_w, out_d, res_z;

    int          checks = 0;
    int          errors = 0;
    int          results_seen = 0;
    logic [31:0] exp_q[$];
    logic        hold_v;
    logic [31:0] hold_z, exp_z;

    pe_fp_acc #(.FPW(32), .FIFO_DEPTH(FIFO_DEPTH), .ACC_LEN(ACC_LEN)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .in_w    (in_w),
        .in_d    (in_d),
        .in_v    (in_v),
        .out_w   (out_w),
        .out_d   (out_d),
        .out_v   (out_v),
        .acc_clr (acc_clr),
        .res_z   (res_z),
        .res_v   (res_v),
        .res_rdy (res_rdy),
        .busy    (busy),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result monitor: compares accepted results and checks that a stalled result is held.
    always @(negedge clk) begin
        if (!rstn) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                checks++;
                if (!res_v || res_z !== hold_z) begin
                    errors++;
                    $display("FAIL hold_stable: res_v=%0b res_z=%h, required res_v=1 res_z=%h",
                             res_v, res_z, hold_z);
                end
            end
            if (res_v && res_rdy) begin
                results_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: res_z=%h, required no result", res_z);
                end else begin
                    exp_z = exp_q.pop_front();
                    if (res_z !== exp_z) begin
                        errors++;
                        $display("FAIL result: res_z=%h, required %h", res_z, exp_z);
                    end
                end
            end
            hold_v = res_v && !res_rdy;
            hold_z = res_z;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] d);
        in_w = w;
        in_d = d;
        in_v = 1'b1;
        tick(1);
        in_v = 1'b0;
    endtask

    task automatic wait_drain(input string name, input bit need_idle);
        int n = 0;
        while ((exp_q.size() != 0 || (need_idle && busy)) && n < 3000) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_timeout: pending=%0d busy=%0b, required 0/0", name, exp_q.size(),
                     busy);
        end
        tick(2);
    endtask

    task automatic wait_state(input string name, input logic [2:0] st, input int cnt);
        int n = 0;
        while (!(dut.state_q == st && int'(dut.cnt_q) == cnt) && n < 500) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL %s_timeout: state=%0d, required %0d", name, dut.state_q, st);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        rstn = 1'b0; acc_clr = 1'b0; res_rdy = 1'b1;
        in_w = 32'hFFFF_FFFF; in_d = 32'hFFFF_FFFF; in_v = 1'b1;
        tick(2);
        chk("rst_out_v", {31'h0, out_v}, 32'h0);
        chk("rst_out_w", out_w, 32'h0);
        chk("rst_res_v", {31'h0, res_v}, 32'h0);
        chk("rst_res_z", res_z, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_ovf", {31'h0, ovf}, 32'h0);
        in_v = 1'b0; in_w = 32'h0; in_d = 32'h0;
        rstn = 1'b1;
        tick(2);

        // Forwarding, first pair of the basic dot product.
        exp_q.push_back(32'h41000000);
        in_w = F_1; in_d = F_2; in_v = 1'b1;
        tick(1);
        in_v = 1'b0;
        chk("fwd_out_w", out_w, F_1);
        chk("fwd_out_d", out_d, F_2);
        chk("fwd_out_v", {31'h0, out_v}, 32'h1);
        tick(1);
        chk("fwd_out_v_low", {31'h0, out_v}, 32'h0);
        repeat (3) begin
            tick(38);
            send(F_1, F_2);
        end
        wait_drain("basic", 1'b1);
        chk("basic_pulses", results_seen, 1);
        chk("basic_ovf", {31'h0, ovf}, 32'h0);

        // Mixed signs: 3 - 2 + 0.75 + 4 = 5.75.
        exp_q.push_back(32'h40B80000);
        send(F_15, F_2);  tick(10);
        send(F_N05, F_4); tick(10);
        send(F_3, F_025); tick(10);
        send(F_2, F_2);
        wait_drain("mixed", 1'b1);

        // Backpressure in DONE while two more pairs queue up.
        res_rdy = 1'b0;
        exp_q.push_back(32'h41000000);
        repeat (4) begin
            send(F_1, F_2);
            tick(10);
        end
        n = 0;
        while (!res_v && n < 500) begin
            tick(1);
            n++;
        end
        chk("bp_res_v", {31'h0, res_v}, 32'h1);
        send(F_1, F_2); tick(2);
        send(F_1, F_2);
        tick(100);
        chk("bp_res_v_held", {31'h0, res_v}, 32'h1);
        chk("bp_res_z_held", res_z, 32'h41000000);
        chk("bp_busy", {31'h0, busy}, 32'h1);
        exp_q.push_back(32'h41000000);
        res_rdy = 1'b1;
        tick(5);
        send(F_1, F_2); tick(20);
        send(F_1, F_2);
        wait_drain("bp", 1'b1);

        // Abort during the second add; a push while the clear is pending must be flushed.
        seen = results_seen;
        send(F_1, F_2); tick(3);
        send(F_1, F_2);
        wait_state("abort_wait", 3'd4, 1);
        acc_clr = 1'b1;
        tick(1);
        acc_clr = 1'b0;
        send(F_1, F_16);
        n = 0;
        while (busy && n < 200) begin
            tick(1);
            n++;
        end
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_no_result", results_seen, seen);
        chk("abort_acc", res_z, 32'h0);
        exp_q.push_back(32'h41000000);
        repeat (4) begin
            send(F_1, F_2);
            tick(10);
        end
        wait_drain("after_abort", 1'b1);

        // Overflow: 8 back-to-back pairs, result from the first four accepted.
        exp_q.push_back(F_4);
        in_w = F_1; in_d = F_1; in_v = 1'b1;
        tick(8);
        in_v = 1'b0;
        wait_drain("ovf", 1'b0);
        chk("ovf_set", {31'h0, ovf}, 32'h1);
        wait_state("mulwt_wait", 3'd2, 0);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_ovf", {31'h0, ovf}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_res_v", {31'h0, res_v}, 32'h0);
        chk("arst_res_z", res_z, 32'h0);
        chk("arst_out_v", {31'h0, out_v}, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick(2);

        // Zero operands after restart.
        exp_q.push_back(F_0);
        repeat (4) begin
            send(F_0, F_5);
            tick(10);
        end
        wait_drain("zero", 1'b1);

        // Clear coincident with result acceptance: one result only.
        res_rdy = 1'b0;
        repeat (4) begin
            send(F_1, F_2);
            tick(10);
        end
        n = 0;
        while (!res_v && n < 500) begin
            tick(1);
            n++;
        end
        seen = results_seen;
        exp_q.push_back(32'h41000000);
        acc_clr = 1'b1;
        res_rdy = 1'b1;
        tick(1);
        acc_clr = 1'b0;
        tick(20);
        chk("clr_consume_count", results_seen, seen + 1);
        chk("clr_consume_res_v", {31'h0, res_v}, 32'h0);
        chk("clr_consume_busy", {31'h0, busy}, 32'h0);
        chk("pending_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
